// File: rtl/rotary_pkg.sv
// Shared constants for the rotary-encoder operand-entry ALU:
// mode encodings, state indices, synchroniser depth, state count helper.
package rotary_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ADDC = 2'b10;
  localparam logic [1:0] MODE_RSUB = 2'b11;

  localparam int ST_CLEAR = 0;
  localparam int ST_A0    = 1;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_e;

  // CLEAR + A digits + B digits + MODE + RESULT
  function automatic int calc_nstate(int width, int digit_w);
    return 2 * (width / digit_w) + 3;
  endfunction

endpackage

// File: rtl/rotary_quad_decoder.sv
// Quadrature step decoder: 2-flop synchronisers, optional debounce
// filter (ROT_DEBOUNCE_EN), level/direction registers.
// Ports: clk, reset (async high), rot_a_i, rot_b_i in;
//        step_cw_o, step_ccw_o one-cycle step pulses out.
module rotary_quad_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rot_a_i,
  input  logic rot_b_i,
  output logic step_cw_o,
  output logic step_ccw_o
);

`ifdef ROT_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  // Synchronisers reset to 1 so an encoder resting at 11
  // looks unchanged when reset releases.
  logic [SYNC_STAGES-1:0] sa_q, sb_q;
  logic [1:0] raw, filt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_q <= '1;
      sb_q <= '1;
    end else begin
      sa_q <= {sa_q[SYNC_STAGES-2:0], rot_a_i};
      sb_q <= {sb_q[SYNC_STAGES-2:0], rot_b_i};
    end
  end

  assign raw = {sa_q[SYNC_STAGES-1], sb_q[SYNC_STAGES-1]};

  if (DEB_EN && DEBOUNCE_CYCLES > 0) begin : g_deb
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]            filt_q;
    logic [1:0][CNT_W-1:0] cnt_q;

    // Filtered bit flips on the DEBOUNCE_CYCLES-th
    // consecutive sample that disagrees with it.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        filt_q <= '1;
        cnt_q  <= '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (raw[i] == filt_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_q[i] <= raw[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end

    assign filt = filt_q;
  end else begin : g_raw
    assign filt = raw;
  end

  logic level_q, prev_q;
  dir_e dir_q;

  // Level and its previous value reset to 1: the
  // first step needs a trip through 00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      dir_q   <= DIR_CW;
    end else begin
      prev_q <= level_q;
      unique case (filt)
        2'b00: level_q <= 1'b0;
        2'b11: level_q <= 1'b1;
        2'b01: dir_q   <= DIR_CW;
        2'b10: dir_q   <= DIR_CCW;
      endcase
    end
  end

  logic rise;
  assign rise       = level_q & ~prev_q;
  assign step_cw_o  = rise & (dir_q == DIR_CW);
  assign step_ccw_o = rise & (dir_q == DIR_CCW);

endmodule

// File: rtl/rotary_alu.sv
// Rotary operand-entry ALU: walks a state index with encoder steps,
// loads A/B digits and mode on CW steps, registers ALU result.
// Ports: clk, reset (async high), ROT_A, ROT_B, holder in;
//        led (result+carry), ovf, step, step_pulse out.
// Optional debounce filter: define ROT_DEBOUNCE_EN.
module rotary_alu
  import rotary_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DIGIT_W         = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  localparam int NSTATE = calc_nstate(WIDTH, DIGIT_W),
  localparam int SW     = $clog2(NSTATE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ROT_A,
  input  logic               ROT_B,
  input  logic [DIGIT_W-1:0] holder,
  output logic [WIDTH:0]     led,
  output logic               ovf,
  output logic [SW-1:0]      step,
  output logic               step_pulse
);

  localparam int NDIG    = WIDTH / DIGIT_W;
  localparam int ST_MODE = 2 * NDIG + 1;

  logic cw, ccw;

  rotary_quad_decoder #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dec (
    .clk       (clk),
    .reset     (reset),
    .rot_a_i   (ROT_A),
    .rot_b_i   (ROT_B),
    .step_cw_o (cw),
    .step_ccw_o(ccw)
  );

  logic [SW-1:0]    step_q, step_d, dst;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH:0]   led_q, sum;
  logic             ovf_q, ovf_c, pulse_q;

  always_comb begin
    step_d = step_q;
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    dst    = step_q;
    if (cw) begin
      dst = (step_q == SW'(NSTATE - 1)) ? '0 : step_q + SW'(1);
    end else if (ccw) begin
      dst = (step_q == '0) ? SW'(NSTATE - 1) : step_q - SW'(1);
    end
    if (cw || ccw) step_d = dst;
    // Loads go to the destination slot, most
    // significant digit first.
    if (cw) begin
      for (int i = 0; i < NDIG; i++) begin
        if (dst == SW'(ST_A0 + i))
          a_d[WIDTH-1-i*DIGIT_W -: DIGIT_W] = holder;
        if (dst == SW'(ST_A0 + NDIG + i))
          b_d[WIDTH-1-i*DIGIT_W -: DIGIT_W] = holder;
      end
      if (dst == SW'(ST_MODE)) mode_d = holder[1:0];
    end
    if ((cw || ccw) && dst == SW'(ST_CLEAR)) begin
      a_d    = '0;
      b_d    = '0;
      mode_d = MODE_ADD;
    end
  end

  logic [WIDTH-1:0] op_x, op_y;
  logic             cin;

  // Every mode is one adder: x + y + cin.
  always_comb begin
    op_x = a_q;
    op_y = b_q;
    cin  = 1'b0;
    unique case (mode_q)
      MODE_ADD:  ;
      MODE_SUB: begin
        op_y = ~b_q;
        cin  = 1'b1;
      end
      MODE_ADDC: cin = 1'b1;
      MODE_RSUB: begin
        op_x = b_q;
        op_y = ~a_q;
        cin  = 1'b1;
      end
    endcase
    sum = {1'b0, op_x} + {1'b0, op_y}
        + {{WIDTH{1'b0}}, cin};
    ovf_c = (op_x[WIDTH-1] == op_y[WIDTH-1])
         && (sum[WIDTH-1] != op_x[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_ADD;
      led_q   <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      led_q   <= sum;
      ovf_q   <= ovf_c;
      pulse_q <= cw | ccw;
    end
  end

  assign led        = led_q;
  assign ovf        = ovf_q;
  assign step       = step_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_rotary_alu.sv
// Directed bench for rotary_alu: step scoreboard plus
// reference-model checks of led/ovf after each step.
module tb_rotary_alu;

`ifdef ROT_DEBOUNCE_EN
  localparam int LAT = 4 + 16;
`else
  localparam int LAT = 4;
`endif

  logic       clk;
  logic       reset;
  logic       ROT_A, ROT_B;
  logic [3:0] holder;
  logic [8:0] led;
  logic       ovf;
  logic [2:0] step;
  logic       step_pulse;

  int checks   = 0;
  int failures = 0;

  int exp_q[$];
  int m_step, m_a, m_b, m_mode;

  rotary_alu dut (
    .clk       (clk),
    .reset     (reset),
    .ROT_A     (ROT_A),
    .ROT_B     (ROT_B),
    .holder    (holder),
    .led       (led),
    .ovf       (ovf),
    .step      (step),
    .step_pulse(step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int model_led();
    int u;
    case (m_mode)
      0:       u = m_a + m_b;
      1:       u = m_a + 256 - m_b;
      2:       u = m_a + m_b + 1;
      default: u = m_b + 256 - m_a;
    endcase
    return u & 'h1FF;
  endfunction

  function automatic int model_ovf();
    int s;
    case (m_mode)
      0:       s = sx(m_a) + sx(m_b);
      1:       s = sx(m_a) - sx(m_b);
      2:       s = sx(m_a) + sx(m_b) + 1;
      default: s = sx(m_b) - sx(m_a);
    endcase
    return (s > 127 || s < -128) ? 1 : 0;
  endfunction

  function automatic void model_cw(input int h);
    m_step = (m_step == 6) ? 0 : m_step + 1;
    case (m_step)
      0: begin m_a = 0; m_b = 0; m_mode = 0; end
      1: m_a = (m_a & 'h0F) | (h << 4);
      2: m_a = (m_a & 'hF0) | h;
      3: m_b = (m_b & 'h0F) | (h << 4);
      4: m_b = (m_b & 'hF0) | h;
      5: m_mode = h & 3;
      default: ;
    endcase
  endfunction

  function automatic void model_ccw();
    m_step = (m_step == 0) ? 6 : m_step - 1;
    if (m_step == 0) begin
      m_a = 0; m_b = 0; m_mode = 0;
    end
  endfunction

  // Scoreboard: every pulse must match a queued step.
  always @(negedge clk) begin
    if (!reset && step_pulse) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL pulse_unexpected observed=1 expected=0");
      end
      if (exp_q.size() > 0) chk("sb_step", step, exp_q.pop_front());
    end
  end

  task automatic phase(input logic [1:0] ab, input int n);
    {ROT_A, ROT_B} = ab;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_step"}, step, m_step);
    chk({tag, "_led"}, led, model_led());
    chk({tag, "_ovf"}, ovf, model_ovf());
  endtask

  task automatic cw_step(input int h, input string tag);
    @(negedge clk);
    holder = h[3:0];
    phase(2'b00, 3);
    phase(2'b01, 3);
    model_cw(h);
    exp_q.push_back(m_step);
    phase(2'b11, LAT + 2);
    check_outputs(tag);
  endtask

  task automatic ccw_step(input int h, input string tag);
    @(negedge clk);
    holder = h[3:0];
    phase(2'b00, 3);
    phase(2'b10, 3);
    model_ccw();
    exp_q.push_back(m_step);
    phase(2'b11, LAT + 2);
    check_outputs(tag);
  endtask

  initial begin
    reset  = 1'b1;
    ROT_A  = 1'b1;
    ROT_B  = 1'b1;
    holder = 4'h0;
    m_step = 0; m_a = 0; m_b = 0; m_mode = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_step", step, 0);
    chk("rst_led", led, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_pulse", step_pulse, 0);

    // First step with exact latency check.
    holder = 4'h3;
    phase(2'b00, 3);
    phase(2'b01, 3);
    model_cw(3);
    exp_q.push_back(m_step);
    {ROT_A, ROT_B} = 2'b11;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_pulse_e%0d", k), step_pulse,
          (k == LAT) ? 1 : 0);
      if (k == LAT) chk("lat_step", step, 1);
    end
    chk("first_led", led, 'h030);

    // A=3C B=05 add
    cw_step('hC, "a_lo");
    cw_step('h0, "b_hi");
    cw_step('h5, "b_lo");
    cw_step('h0, "mode_add");
    cw_step('hA, "res_add");
    chk("add_led_const", led, 'h041);

    // A=05 B=06 sub then rsub
    cw_step('h0, "clr1");
    cw_step('h0, "a5_hi");
    cw_step('h5, "a5_lo");
    cw_step('h0, "b6_hi");
    cw_step('h6, "b6_lo");
    cw_step('h1, "mode_sub");
    chk("sub_led_const", led, 'h0FF);
    ccw_step('hF, "rev_b");
    cw_step('h3, "mode_rsub");
    chk("rsub_led_const", led, 'h101);

    // A=7F B=01 overflow cases
    cw_step('h0, "to_res");
    cw_step('h0, "clr2");
    cw_step('h7, "a7_hi");
    cw_step('hF, "a7_lo");
    cw_step('h0, "b1_hi");
    cw_step('h1, "b1_lo");
    cw_step('h0, "mode_add2");
    chk("ovf_led_const", led, 'h080);
    chk("ovf_flag_const", ovf, 1);
    ccw_step('h9, "rev_b2");
    cw_step('h2, "mode_addc");
    chk("addc_led_const", led, 'h081);

    // Wrap both ways through CLEAR
    cw_step('h0, "to_res2");
    cw_step('h0, "wrap_cw");
    ccw_step('h7, "wrap_ccw");
    cw_step('h0, "wrap_back");

    // Reset in the middle of a step
    cw_step('h4, "pre_rst");
    @(negedge clk);
    phase(2'b00, 3);
    phase(2'b01, 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_step", step, 0);
    chk("midrst_led", led, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_pulse", step_pulse, 0);
    m_step = 0; m_a = 0; m_b = 0; m_mode = 0;
    exp_q.delete();
    {ROT_A, ROT_B} = 2'b11;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 8) @(negedge clk);
    chk("post_rst_step", step, 0);
    chk("post_rst_led", led, 0);

`ifdef ROT_DEBOUNCE_EN
    phase(2'b00, LAT + 4);
    phase(2'b01, LAT + 4);
    phase(2'b11, 3);
    phase(2'b01, LAT + 4);
    chk("glitch_step", step, 0);
`endif

    cw_step('h9, "after_rst");
    repeat (4) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
